// File: rtl/line_fifo_pkg.sv
// Shared types for the line commit FIFO: per-beat sideband metadata and write FSM states.
package line_fifo_pkg;

  localparam int unsigned MetaWidth = 26;

  typedef struct packed {
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        sof;
    logic        eof;
    logic        sol;
    logic        eol;
  } line_meta_t;

  typedef enum logic [1:0] {
    StIdle,
    StLine,
    StDiscard
  } wr_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when not enabled.
module sdp_ram #(
  parameter int unsigned Width = 58,
  parameter int unsigned Depth = 4096,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register carries the reset so read outputs come up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/line_commit_fifo.sv
// Per-camera line FIFO: lines become readable only once their eol beat is written,
// and partial or overflowing lines are rolled back whole.
module line_commit_fifo
  import line_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned AFULL_LEVEL = DEPTH - 64,
  parameter int unsigned CAMERA_ID   = 0,
  localparam int unsigned PW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ovf_clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_sof,
  input  logic                  wr_eof,
  input  logic                  wr_sol,
  input  logic                  wr_eol,
  input  logic [5:0]            wr_data_type,
  input  logic [15:0]           wr_word_count,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_sof,
  output logic                  rd_eof,
  output logic                  rd_sol,
  output logic                  rd_eol,
  output logic [5:0]            rd_data_type,
  output logic [15:0]           rd_word_count,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [PW-1:0]         level,
  output logic [PW-1:0]         lines_avail,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 16");
  end
  if (CAMERA_ID > 32'hFFFF) begin : g_bad_cam_id
    $error("CAMERA_ID must fit in 16 bits");
  end

  localparam int unsigned WordW = DATA_WIDTH + MetaWidth;

  wr_state_e         state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     lines_q, lines_d, occ, wbase;
  logic              overflow_q, overflow_d, rd_valid_q;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              wr_go, ram_we, commit, drop_full, drop_sol, rd_fire, line_done;
  line_meta_t        wr_meta, rd_meta;
  logic [WordW-1:0]  ram_rdata;

  assign occ         = wr_ptr_q - rd_ptr_q;
  assign full        = (occ == PW'(DEPTH));
  assign almost_full = (occ >= PW'(AFULL_LEVEL));
  assign level       = cmt_ptr_q - rd_ptr_q;
  assign empty       = (rd_ptr_q == cmt_ptr_q);

  assign wr_go = wr_en & ~flush;

  // Write FSM. A line-loss event is only counted for beats that would have been stored:
  // idle orphans and non-sol beats in discard never count, even while full.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wbase     = wr_ptr_q;
    ram_we    = 1'b0;
    commit    = 1'b0;
    drop_full = 1'b0;
    drop_sol  = 1'b0;
    if (wr_go) begin
      if (full && (state_q == StLine || wr_sol)) begin
        drop_full = 1'b1;
        wr_ptr_d  = cmt_ptr_q;
        state_d   = wr_eol ? StIdle : StDiscard;
      end else if (state_q == StLine || wr_sol) begin
        if (state_q == StLine && wr_sol) begin
          drop_sol = 1'b1;
          wbase    = cmt_ptr_q;
        end
        ram_we   = 1'b1;
        wr_ptr_d = wbase + PW'(1);
        if (wr_eol) begin
          cmt_ptr_d = wbase + PW'(1);
          commit    = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StLine;
        end
      end else if (state_q == StDiscard && wr_eol) begin
        state_d = StIdle;
      end
    end
    if (flush) begin
      wr_ptr_d  = '0;
      cmt_ptr_d = '0;
      state_d   = StIdle;
    end
  end

  assign rd_fire   = rd_en & ~empty & ~flush;
  assign line_done = rd_valid_q & rd_meta.eol;

  always_comb begin
    rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(rd_fire);
    lines_d    = flush ? '0 : lines_q + PW'(commit) - PW'(line_done);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    // A drop in the same cycle as a clear leaves exactly that one drop recorded.
    if (drop_full || drop_sol) begin
      if (ovf_clr) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      lines_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lines_q    <= lines_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= rd_fire;
    end
  end

  assign wr_meta = '{dt: wr_data_type, wc: wr_word_count, sof: wr_sof, eof: wr_eof,
                     sol: wr_sol, eol: wr_eol};

  sdp_ram #(
    .Width(WordW),
    .Depth(DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(wbase[PW-2:0]),
    .wdata({wr_meta, wr_data}),
    .re   (rd_fire),
    .raddr(rd_ptr_q[PW-2:0]),
    .rdata(ram_rdata)
  );

  assign {rd_meta, rd_data} = ram_rdata;
  assign rd_sof        = rd_meta.sof;
  assign rd_eof        = rd_meta.eof;
  assign rd_sol        = rd_meta.sol;
  assign rd_eol        = rd_meta.eol;
  assign rd_data_type  = rd_meta.dt;
  assign rd_word_count = rd_meta.wc;
  assign rd_valid      = rd_valid_q;
  assign lines_avail   = lines_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_line_commit_fifo.sv
// Directed bench for line_commit_fifo at DEPTH=16: commit visibility, rollback, flush,
// streaming through wrap-around, and overflow flag/counter behaviour.
module tb_line_commit_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFL   = 12;
  localparam int unsigned PW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0, ovf_clr = 1'b0;
  logic          wr_en = 1'b0, wr_sof = 1'b0, wr_eof = 1'b0, wr_sol = 1'b0, wr_eol = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [5:0]    wr_data_type = 6'h2B;
  logic [15:0]   wr_word_count = 16'd32;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_sof, rd_eof, rd_sol, rd_eol, rd_valid;
  logic [5:0]    rd_data_type;
  logic [15:0]   rd_word_count;
  logic          empty, full, almost_full, overflow;
  logic [PW-1:0] level, lines_avail;
  logic [15:0]   drop_count;

  line_commit_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFL),
    .CAMERA_ID  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_sof       (wr_sof),
    .wr_eof       (wr_eof),
    .wr_sol       (wr_sol),
    .wr_eol       (wr_eol),
    .wr_data_type (wr_data_type),
    .wr_word_count(wr_word_count),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_sof       (rd_sof),
    .rd_eof       (rd_eof),
    .rd_sol       (rd_sol),
    .rd_eol       (rd_eol),
    .rd_data_type (rd_data_type),
    .rd_word_count(rd_word_count),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .level        (level),
    .lines_avail  (lines_avail),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr_en, sol, eol, rd_en;
    logic [31:0] data;
    logic        e_empty;
    int          e_level, e_lines;
    logic        e_valid, e_sol, e_eol;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic sol, input logic eol);
    wr_en   = 1'b1;
    wr_data = d;
    wr_sol  = sol;
    wr_eol  = eol;
    tick();
    wr_en   = 1'b0;
    wr_sol  = 1'b0;
    wr_eol  = 1'b0;
  endtask

  task automatic put_line(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) put(base + i, i == 0, i == n - 1);
  endtask

  task automatic get_line(input string name, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk($sformatf("%s_valid[%0d]", name, i), rd_valid, 1);
      chk($sformatf("%s_data[%0d]", name, i), rd_data, base + i);
      chk($sformatf("%s_eol[%0d]", name, i), rd_eol, i == n - 1);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, lvl_bad;

    // Single 8-beat line written, then read back; idle cycle shows lines_avail falling.
    for (int i = 0; i < 17; i++) begin
      tbl[i] = '{wr_en: 1'b0, sol: 1'b0, eol: 1'b0, rd_en: 1'b0, data: 32'h0,
                 e_empty: 1'b1, e_level: 0, e_lines: 0, e_valid: 1'b0, e_sol: 1'b0,
                 e_eol: 1'b0, e_data: 32'h0};
      if (i < 8) begin
        tbl[i].wr_en = 1'b1;
        tbl[i].data  = 32'hA0 + i;
        tbl[i].sol   = (i == 0);
        tbl[i].eol   = (i == 7);
        if (i == 7) begin
          tbl[i].e_empty = 1'b0;
          tbl[i].e_level = 8;
          tbl[i].e_lines = 1;
        end
      end else if (i < 16) begin
        tbl[i].rd_en   = 1'b1;
        tbl[i].e_empty = (i == 15);
        tbl[i].e_level = 15 - i;
        tbl[i].e_lines = 1;
        tbl[i].e_valid = 1'b1;
        tbl[i].e_sol   = (i == 8);
        tbl[i].e_eol   = (i == 15);
        tbl[i].e_data  = 32'hA0 + (i - 8);
      end else begin
        tbl[i].e_eol  = 1'b1;
        tbl[i].e_data = 32'hA7;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_lines", lines_avail, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_eol", rd_eol, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      wr_en   = tbl[i].wr_en;
      wr_data = tbl[i].data;
      wr_sol  = tbl[i].sol;
      wr_sof  = tbl[i].sol;
      wr_eol  = tbl[i].eol;
      rd_en   = tbl[i].rd_en;
      tick();
      {wr_en, wr_sol, wr_sof, wr_eol, rd_en} = '0;
      chk($sformatf("t1_empty[%0d]", i), empty, tbl[i].e_empty);
      chk($sformatf("t1_level[%0d]", i), level, tbl[i].e_level);
      chk($sformatf("t1_lines[%0d]", i), lines_avail, tbl[i].e_lines);
      chk($sformatf("t1_valid[%0d]", i), rd_valid, tbl[i].e_valid);
      chk($sformatf("t1_data[%0d]", i), rd_data, tbl[i].e_data);
      chk($sformatf("t1_sol[%0d]", i), rd_sol, tbl[i].e_sol);
      chk($sformatf("t1_sof[%0d]", i), rd_sof, tbl[i].e_sol);
      chk($sformatf("t1_eol[%0d]", i), rd_eol, tbl[i].e_eol);
    end
    chk("t1_dt", rd_data_type, 6'h2B);
    chk("t1_wc", rd_word_count, 16'd32);

    // Orphans in idle are not stored; sol inside a line drops the partial line.
    for (int i = 0; i < 3; i++) put(32'h11 + i, 1'b0, 1'b0);
    chk("orph_level", level, 0);
    chk("orph_empty", empty, 1);
    put(32'h20, 1'b1, 1'b0);
    put(32'h21, 1'b0, 1'b0);
    chk("orph_partial_empty", empty, 1);
    put_line(32'h30, 4);
    chk("orph_drops", drop_count, 1);
    chk("orph_overflow", overflow, 0);
    chk("orph_level4", level, 4);
    chk("orph_lines", lines_avail, 1);
    get_line("orph_rd", 32'h30, 4);
    tick();
    chk("orph_empty_after", empty, 1);
    chk("orph_lines_after", lines_avail, 0);

    // Overflow: 10 committed + 6 speculative fills storage; the 7th beat rolls back.
    put_line(32'h100, 10);
    chk("ovf_level_a", level, 10);
    chk("ovf_afull_a", almost_full, 0);
    for (int i = 0; i < 6; i++) put(32'h200 + i, i == 0, 1'b0);
    chk("ovf_full", full, 1);
    chk("ovf_afull", almost_full, 1);
    chk("ovf_level_spec", level, 10);
    put(32'h206, 1'b0, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    chk("ovf_full_after", full, 0);
    chk("ovf_level_after", level, 10);
    chk("ovf_lines_after", lines_avail, 1);
    put(32'h207, 1'b0, 1'b0);
    put(32'h208, 1'b0, 1'b0);
    put(32'h209, 1'b0, 1'b1);
    chk("ovf_tail_level", level, 10);
    chk("ovf_tail_drops", drop_count, 2);
    get_line("ovf_rd", 32'h100, 10);
    tick();
    chk("ovf_empty_end", empty, 1);
    chk("ovf_lines_end", lines_avail, 0);

    // Flush mid-line with two committed lines; coincident write and read are dropped.
    put_line(32'h400, 3);
    put_line(32'h410, 3);
    put(32'h420, 1'b1, 1'b0);
    put(32'h421, 1'b0, 1'b0);
    chk("fl_level_pre", level, 6);
    chk("fl_lines_pre", lines_avail, 2);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'h4FF;
    wr_sol  = 1'b1;
    rd_en   = 1'b1;
    tick();
    {flush, wr_en, wr_sol, rd_en} = '0;
    chk("fl_empty", empty, 1);
    chk("fl_level", level, 0);
    chk("fl_lines", lines_avail, 0);
    chk("fl_valid", rd_valid, 0);
    chk("fl_full", full, 0);
    chk("fl_overflow", overflow, 1);
    chk("fl_drops", drop_count, 2);
    put_line(32'h500, 2);
    chk("fl_new_level", level, 2);
    chk("fl_new_lines", lines_avail, 1);
    get_line("fl_rd", 32'h500, 2);
    tick();
    chk("fl_new_lines_end", lines_avail, 0);

    // Continuous 4-beat lines, 3*DEPTH beats, reader always requesting.
    got     = 0;
    lvl_bad = 0;
    rd_en   = 1'b1;
    for (int k = 0; k < 56; k++) begin
      if (k < 48) begin
        wr_en   = 1'b1;
        wr_data = 32'h300 + k;
        wr_sol  = (k % 4 == 0);
        wr_eol  = (k % 4 == 3);
      end
      tick();
      {wr_en, wr_sol, wr_eol} = '0;
      if (rd_valid) begin
        chk($sformatf("st_data[%0d]", got), rd_data, 32'h300 + got);
        got++;
      end
      if (level > AFL) lvl_bad++;
    end
    rd_en = 1'b0;
    chk("st_count", got, 48);
    chk("st_level_bound", lvl_bad, 0);
    chk("st_drops", drop_count, 2);
    chk("st_empty", empty, 1);

    // ovf_clr coinciding with an overflow drop, ovf_clr alone, then saturation.
    put_line(32'h600, 16);
    chk("sat_full", full, 1);
    chk("sat_level", level, 16);
    chk("sat_afull", almost_full, 1);
    ovf_clr = 1'b1;
    put(32'h700, 1'b1, 1'b0);
    ovf_clr = 1'b0;
    chk("clr_same_ovf", overflow, 1);
    chk("clr_same_drops", drop_count, 1);
    chk("clr_same_level", level, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone_ovf", overflow, 0);
    chk("clr_alone_drops", drop_count, 0);
    for (int i = 0; i < 70000; i++) put(32'h800, 1'b1, 1'b1);
    chk("sat_drops", drop_count, 16'hFFFF);
    chk("sat_ovf", overflow, 1);
    chk("sat_level_kept", level, 16);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_empty", empty, 1);
    chk("sat_flush_drops", drop_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
